sdio_read_api: RTL and testbench

- Read-direction counterpart of the SDIO command/SDRAM-write path.
- Services SDIO read-back requests: sets a read pointer, fetches two consecutive 16-bit SDRAM words per request, and returns them packed as a 32-bit response argument.
- Sits between the SDIO request/response channel and a read port of the SDRAM arbiter.
- Lets the host verify loaded PRG/CHR images.

---
 rtl/sdio_read_api.sv | 196 +++++++++++++++++++
 tb/tb_sdio_read_api.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_read_api.sv
// sdio_read_api: SDIO read-back path. It keeps a read pointer, fetches two
// consecutive 16-bit SDRAM words per READ2 request and returns them packed
// as {hi, lo}. Commands handled: 5 SET_PTR, 6 READ2, 7 GET_PTR.
// Optional macro SDIO_READ_CHECKSUM_EN adds a running XOR checksum of the
// words returned by READ2, which cmd 8 reads back and cmd 5 clears.
//
// state   | meaning
// IDLE    | no fetch in progress, commands decoded
// REQ_LO  | one-cycle SDRAM read of ptr
// WAIT_LO | wait for low word (with timeout)
// REQ_HI  | one-cycle SDRAM read of ptr+1
// WAIT_HI | wait for high word (with timeout)
// RESP    | load fetch response, advance ptr on success
module sdio_read_api #(
  parameter int ADDR_BITS      = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [5:0]           req_cmd,
  input  logic [31:0]          req_arg,
  output logic                 resp_valid,
  output logic [31:0]          resp_arg,
  output logic                 resp_err,
  output logic                 ram_read,
  output logic [ADDR_BITS-1:0] ram_address,
  input  logic [15:0]          ram_data_read,
  input  logic                 ram_ready,
  output logic                 busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] PTR_TWO  = ADDR_BITS'(2);

  typedef enum logic [2:0] {
    IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP
  } state_t;

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] fail_addr;
  logic [15:0]          lo, hi;
  logic [CNT_W-1:0]     cnt;
  logic                 fetch_err;
  logic                 pend_err;
  logic                 req_hit;
  logic                 waiting;
  logic                 timeout_hit;
`ifdef SDIO_READ_CHECKSUM_EN
  logic [15:0]          csum;
`endif

  // Decode which strobed commands belong to this block.
  always_comb begin
    req_hit = 1'b0;
    if (req_valid) begin
      case (req_cmd)
        6'd5, 6'd6, 6'd7: req_hit = 1'b1;
`ifdef SDIO_READ_CHECKSUM_EN
        6'd8:             req_hit = 1'b1;
`endif
        default:          req_hit = 1'b0;
      endcase
    end
  end

  assign waiting     = (state == WAIT_LO) || (state == WAIT_HI);
  assign timeout_hit = waiting && !ram_ready && (cnt == CNT_LAST);
  assign fail_addr   = (state == WAIT_HI) ? ptr + PTR_ONE : ptr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a READ2 arriving while an error is pending is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_hit && req_cmd == 6'd6 && !pend_err) state_nx = REQ_LO;
      REQ_LO:  state_nx = WAIT_LO;
      WAIT_LO: if (ram_ready) state_nx = REQ_HI;
               else if (timeout_hit) state_nx = RESP;
      REQ_HI:  state_nx = WAIT_HI;
      WAIT_HI: if (ram_ready || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // SDRAM request outputs and busy flag, decoded from state.
  always_comb begin
    ram_read    = 1'b0;
    ram_address = '0;
    busy        = (state != IDLE);
    case (state)
      REQ_LO: begin
        ram_read    = 1'b1;
        ram_address = ptr;
      end
      REQ_HI: begin
        ram_read    = 1'b1;
        ram_address = ptr + PTR_ONE;
      end
      default: ;
    endcase
  end

  // Datapath: wait counter, word capture, pointer and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_arg   <= '0;
      resp_err   <= 1'b0;
      ptr        <= '0;
      lo         <= '0;
      hi         <= '0;
      cnt        <= '0;
      fetch_err  <= 1'b0;
      pend_err   <= 1'b0;
`ifdef SDIO_READ_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;

      if (waiting && !ram_ready && !timeout_hit) cnt <= cnt + CNT_ONE;
      else                                       cnt <= '0;

      if (state == REQ_LO) fetch_err <= 1'b0;
      if (waiting && ram_ready) begin
        if (state == WAIT_LO) lo <= ram_data_read;
        else                  hi <= ram_data_read;
      end
      // On timeout the error word is staged in {hi, lo} so RESP is uniform.
      if (timeout_hit) begin
        fetch_err <= 1'b1;
        hi        <= 16'hDEAD;
        lo        <= 16'(fail_addr);
      end

      if (state == RESP) begin
        resp_valid <= 1'b1;
        resp_arg   <= {hi, lo};
        resp_err   <= fetch_err;
        if (!fetch_err) begin
          ptr  <= ptr + PTR_TWO;
`ifdef SDIO_READ_CHECKSUM_EN
          csum <= csum ^ lo ^ hi;
`endif
        end
        if (req_hit) pend_err <= 1'b1;
      end else if (pend_err) begin
        resp_valid <= 1'b1;
        resp_arg   <= 32'hB5B5_0000;
        resp_err   <= 1'b1;
        pend_err   <= 1'b0;
      end else if (req_hit && state != IDLE) begin
        resp_valid <= 1'b1;
        resp_arg   <= 32'hB5B5_0000;
        resp_err   <= 1'b1;
      end else if (req_hit) begin
        case (req_cmd)
          6'd5: begin
            ptr        <= ADDR_BITS'(req_arg);
            resp_valid <= 1'b1;
            resp_arg   <= '0;
            resp_err   <= 1'b0;
`ifdef SDIO_READ_CHECKSUM_EN
            csum       <= '0;
`endif
          end
          6'd7: begin
            resp_valid <= 1'b1;
            resp_arg   <= 32'(ptr);
            resp_err   <= 1'b0;
          end
`ifdef SDIO_READ_CHECKSUM_EN
          6'd8: begin
            resp_valid <= 1'b1;
            resp_arg   <= {16'h0, csum};
            resp_err   <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdio_read_api.sv
// Scoreboard bench for sdio_read_api: expected responses are queued when a
// request is issued and popped by a monitor whenever resp_valid is seen.
module tb_sdio_read_api;
  localparam int AB = 24;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [5:0]    req_cmd = '0;
  logic [31:0]   req_arg = '0;
  logic          resp_valid;
  logic [31:0]   resp_arg;
  logic          resp_err;
  logic          ram_read;
  logic [AB-1:0] ram_address;
  logic [15:0]   ram_data_read = '0;
  logic          ram_ready = 1'b0;
  logic          busy;

  sdio_read_api #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_arg(req_arg), .resp_valid(resp_valid), .resp_arg(resp_arg),
    .resp_err(resp_err), .ram_read(ram_read), .ram_address(ram_address),
    .ram_data_read(ram_data_read), .ram_ready(ram_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] arg;
    int          at;
  } exp_t;

  exp_t          exp_q[$];
  logic [AB-1:0] addr_q[$];
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%0h err=%0b required=no response (cycle %0d)",
                 resp_arg, resp_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_arg", resp_arg, mon_e.arg);
        check("resp_err", resp_err, mon_e.err);
        check("resp_cycle", cyc, mon_e.at);
      end
    end
  end

  // SDRAM model: checks each read address, answers rdy_delay cycles later.
  int          rdy_delay = 3;
  bit          ram_en = 1'b1;
  logic [15:0] mem [int];
  int          cd = 0;
  logic [15:0] pend_data = '0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      cd = 0;
      ram_ready = 1'b0;
    end else begin
      ram_ready = 1'b0;
      if (ram_read) begin
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=%0h required=no read", ram_address);
        end else begin
          check("ram_address", ram_address, addr_q.pop_front());
        end
        if (ram_en) begin
          cd = rdy_delay;
          pend_data = mem.exists(int'(ram_address)) ? mem[int'(ram_address)] : 16'h0;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ram_ready = 1'b1;
          ram_data_read = pend_data;
        end
      end
    end
  end

  task automatic send(input logic [5:0] cmd, input logic [31:0] arg);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_arg   = arg;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] arg, input int at);
    exp_t e;
    e.err = err;
    e.arg = arg;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic cmd_now(input logic [5:0] cmd, input logic [31:0] arg,
                         input int lat, input logic err, input logic [31:0] exp_arg);
    expect_resp(err, exp_arg, cyc + lat);
    send(cmd, arg);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_wait(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("FAIL wait_budget actual=%0d pending busy=%0b required=0 pending", exp_q.size(), busy);
      exp_q.delete();
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=time %0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  int c;

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_arg", resp_arg, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a fetch drops it and clears ptr.
    cmd_now(6'd5, 32'h55, 1, 1'b0, 32'h0);
    idle_wait(20);
    rdy_delay = 3;
    addr_q.push_back(24'h55);
    c = cyc;
    send(6'd6, 32'h0);
    wait_until(c + 2);
    check("busy_in_fetch", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_ram_read", ram_read, 0);
    check("midrst_ram_address", ram_address, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h0);
    idle_wait(20);

    // Basic READ2, ready 3 cycles after each read: 10-cycle latency.
    mem[32'h100] = 16'h1234;
    mem[32'h101] = 16'hABCD;
    cmd_now(6'd5, 32'h100, 1, 1'b0, 32'h0);
    idle_wait(20);
    addr_q.push_back(24'h100);
    addr_q.push_back(24'h101);
    cmd_now(6'd6, 32'h0, 10, 1'b0, 32'hABCD_1234);
    idle_wait(40);
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h102);
    idle_wait(20);

    // Ignored command: no response, no state change.
    send(6'd3, 32'h77);
    idle_wait(20);

    // Wrap-around at the top of the address space, ready after 1 cycle.
    rdy_delay = 1;
    mem[32'hFFFFFF] = 16'h5A5A;
    mem[32'h0]      = 16'h0F0F;
    cmd_now(6'd5, 32'h00FF_FFFF, 1, 1'b0, 32'h0);
    idle_wait(20);
    addr_q.push_back(24'hFFFFFF);
    addr_q.push_back(24'h000000);
    cmd_now(6'd6, 32'h0, 6, 1'b0, 32'h0F0F_5A5A);
    idle_wait(40);
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h1);
    idle_wait(20);

    // Timeout on the low word: error word carries the failing address.
    ram_en = 1'b0;
    cmd_now(6'd5, 32'h2345, 1, 1'b0, 32'h0);
    idle_wait(20);
    addr_q.push_back(24'h2345);
    cmd_now(6'd6, 32'h0, TO + 3, 1'b1, 32'hDEAD_2345);
    idle_wait(TO + 40);
    ram_en = 1'b1;
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h2345);
    idle_wait(20);

    // Busy collision during WAIT_LO: error next cycle, read still completes.
    rdy_delay = 3;
    mem[32'h200] = 16'h1111;
    mem[32'h201] = 16'h2222;
    cmd_now(6'd5, 32'h200, 1, 1'b0, 32'h0);
    idle_wait(20);
    addr_q.push_back(24'h200);
    addr_q.push_back(24'h201);
    c = cyc;
    expect_resp(1'b1, 32'hB5B5_0000, c + 3);
    expect_resp(1'b0, 32'h2222_1111, c + 10);
    send(6'd6, 32'h0);
    wait_until(c + 2);
    send(6'd7, 32'h0);
    idle_wait(40);

    // Request landing on the RESP cycle: fetch response first, error after.
    mem[32'h202] = 16'h3333;
    mem[32'h203] = 16'h4444;
    addr_q.push_back(24'h202);
    addr_q.push_back(24'h203);
    c = cyc;
    expect_resp(1'b0, 32'h4444_3333, c + 10);
    expect_resp(1'b1, 32'hB5B5_0000, c + 11);
    send(6'd6, 32'h0);
    wait_until(c + 9);
    send(6'd7, 32'h0);
    idle_wait(40);
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h204);
    idle_wait(20);

`ifdef SDIO_READ_CHECKSUM_EN
    // Checksum: 1^2^4^8 = 0xF.
    mem[32'h0] = 16'h0001;
    mem[32'h1] = 16'h0002;
    mem[32'h2] = 16'h0004;
    mem[32'h3] = 16'h0008;
    cmd_now(6'd5, 32'h0, 1, 1'b0, 32'h0);
    idle_wait(20);
    addr_q.push_back(24'h0);
    addr_q.push_back(24'h1);
    cmd_now(6'd6, 32'h0, 10, 1'b0, 32'h0002_0001);
    idle_wait(40);
    addr_q.push_back(24'h2);
    addr_q.push_back(24'h3);
    cmd_now(6'd6, 32'h0, 10, 1'b0, 32'h0008_0004);
    idle_wait(40);
    cmd_now(6'd8, 32'h0, 1, 1'b0, 32'h0000_000F);
    idle_wait(20);
`else
    // Without the checksum option cmd 8 is ignored.
    send(6'd8, 32'h0);
    idle_wait(20);
    cmd_now(6'd7, 32'h0, 1, 1'b0, 32'h204);
    idle_wait(20);
`endif

    check("addr_q_drained", addr_q.size(), 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
